fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_fft_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// ---------------------------------------------------------------------------
// fft_sequencer
//
// Control sequencer for a pipelined radix-2 FFT made of LOG2N stages that
// share one advance strobe. It accepts input samples with valid/ready
// handshaking and drives each stage's ctrl bit and twiddle address from a
// common tick counter. It also produces the output-side valid, last and
// bin-index markers. A flush request drains the pipeline at the next frame
// boundary and then returns the sequencer to IDLE.
//
// Parameters
//   FFT_N   transform length (power of two, 4..32768)
//   LOG2N   log2(FFT_N), number of stages sequenced
//   BF_LAT  butterfly register latency per stage, in cycles
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input sample present this cycle
//   in_ready   sequencer accepts a sample this cycle (low while draining)
//   flush      single-cycle request to drain after the current frame
//   enable     common advance strobe to every stage
//   ctrl_bus   bit k -> ctrl input of stage k (registered)
//   addr_bus   [16k+15:16k] -> twiddle address of stage k (registered)
//   out_valid  last-stage output is a valid bin (registered)
//   out_last   last bin of an output frame (registered)
//   out_index  bin index of the current output (registered)
//
// Build option
//   FFT_SEQ_BITREV_EN  when defined, out_index is the bit-reversed output
//                      counter, which is the true frequency bin. Otherwise
//                      out_index is the natural arrival order.
// ---------------------------------------------------------------------------
module fft_sequencer #(
    parameter int FFT_N  = 1024,
    parameter int LOG2N  = 10,
    parameter int BF_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic                enable,
    output logic [LOG2N-1:0]    ctrl_bus,
    output logic [16*LOG2N-1:0] addr_bus,
    output logic                out_valid,
    output logic                out_last,
    output logic [LOG2N-1:0]    out_index
);

    // Ticks from the first sample until the first bin appears at the last stage.
    localparam int LAT = FFT_N - 1 + LOG2N * BF_LAT;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_N - 1);

    // Tick at which stage k sees its first valid data.
    function automatic int stage_offset(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s = s + (FFT_N >> (j + 1)) + BF_LAT;
        end
        return s;
    endfunction

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_t;
    logic [31:0]      r_fill;        // saturates at LAT
    logic [31:0]      r_pend;        // samples accepted but not yet output
    logic [LOG2N-1:0] r_o;
    logic [LOG2N-1:0] r_in_cnt;
    logic             r_flush_pend;

    logic             w_accept;
    logic             w_fire;
    logic             w_frame_end;
    logic             w_flush_req;
    logic             w_drain_done;
    logic [LOG2N-1:0] w_ctrl;
    logic [LOG2N-1:0] w_index;
    logic [16*LOG2N-1:0] w_addr;

    assign in_ready = (r_state != DRAIN);
    assign w_accept = in_valid && in_ready;
    // Gating with rst_n keeps the strobe low while reset is held, even in IDLE.
    assign enable   = rst_n && ((r_state == DRAIN) || w_accept);

    assign w_fire       = enable && (r_fill >= 32'(LAT));
    assign w_frame_end  = w_accept && (r_in_cnt == LAST_IDX);
    assign w_flush_req  = ((r_state == FILL) || (r_state == RUN)) && (flush || r_flush_pend);
    // Inputs stop on a frame boundary, so the last pending output is an out_last.
    assign w_drain_done = (r_state == DRAIN) && w_fire && (r_pend == 32'd1);

    // -----------------------------------------------------------------------
    // Per-stage ctrl / twiddle address. Gating on r_fill instead of r_t
    // keeps a stage active after the 16-bit tick counter wraps.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LOG2N; gi++) begin : g_stage
            localparam int D_K = FFT_N >> (gi + 1);
            localparam int O_K = stage_offset(gi);
            logic [15:0] w_tk;
            logic        w_act;
            assign w_tk  = r_t - 16'(O_K);
            assign w_act = (r_fill >= 32'(O_K));
            assign w_ctrl[gi] = w_act && w_tk[LOG2N-1-gi];
            assign w_addr[16*gi +: 16] = w_act ? ((w_tk & 16'(D_K - 1)) << gi) : 16'd0;
        end
    endgenerate

`ifdef FFT_SEQ_BITREV_EN
    generate
        for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign w_index[gi] = r_o[LOG2N-1-gi];
        end
    endgenerate
`else
    assign w_index = r_o;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (w_frame_end && w_flush_req) begin
                    w_state_next = DRAIN;
                end else if (enable && (r_fill + 32'd1 >= 32'(LAT))) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_frame_end && w_flush_req) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_t          <= '0;
            r_fill       <= '0;
            r_pend       <= '0;
            r_o          <= '0;
            r_in_cnt     <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // A latched flush is consumed on entry to DRAIN; flush outside
            // FILL/RUN is ignored.
            if (w_state_next == DRAIN) begin
                r_flush_pend <= 1'b0;
            end else if (flush && ((r_state == FILL) || (r_state == RUN))) begin
                r_flush_pend <= 1'b1;
            end

            if (w_drain_done) begin
                r_t      <= '0;
                r_fill   <= '0;
                r_pend   <= '0;
                r_o      <= '0;
                r_in_cnt <= '0;
            end else if (enable) begin
                r_t <= r_t + 16'd1;
                if (r_fill < 32'(LAT)) begin
                    r_fill <= r_fill + 32'd1;
                end
                if (w_fire) begin
                    r_o <= r_o + 1'b1;
                end
                if (w_accept) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
                case ({w_accept, w_fire})
                    2'b10:   r_pend <= r_pend + 32'd1;
                    2'b01:   r_pend <= r_pend - 32'd1;
                    default: r_pend <= r_pend;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered stage controls and output markers; they hold while enable is low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_bus  <= '0;
            addr_bus  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
        end else if (enable) begin
            ctrl_bus  <= w_ctrl;
            addr_bus  <= w_addr;
            out_valid <= w_fire;
            out_last  <= w_fire && (r_o == LAST_IDX);
            out_index <= w_index;
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_sequencer
//
// Directed bench for fft_sequencer at FFT_N=16, LOG2N=4, BF_LAT=1 (LAT=19).
// The stage offsets are 0, 9, 14 and 17. Inputs change 1 ns after a rising
// edge. Combinational outputs are sampled 1 ns later. Registered outputs are
// sampled 1 ns after the edge that loaded them.
// ---------------------------------------------------------------------------
module tb_fft_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        enable;
    logic [3:0]  ctrl_bus;
    logic [63:0] addr_bus;
    logic        out_valid;
    logic        out_last;
    logic [3:0]  out_index;

    int checks   = 0;
    int failures = 0;

`ifdef FFT_SEQ_BITREV_EN
    logic [3:0] idx_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
`else
    logic [3:0] idx_tab [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`endif
    logic [15:0] a1_tab [4] = '{16'd0, 16'd2, 16'd4, 16'd6};
    logic [15:0] a0_resume [3] = '{16'd6, 16'd7, 16'd0};

    always #5 clk = ~clk;

    fft_sequencer #(
        .FFT_N (16),
        .LOG2N (4),
        .BF_LAT(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .enable   (enable),
        .ctrl_bus (ctrl_bus),
        .addr_bus (addr_bus),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_index(out_index)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (ctrl_bus !== 4'h0 || addr_bus !== 64'h0) begin failures++; $display("FAIL reset_buses ctrl=%h addr=%h exp=0", ctrl_bus, addr_bus); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== 4'h0) begin
            failures++; $display("FAIL reset_out valid=%b last=%b idx=%0d exp=0", out_valid, out_last, out_index); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL idle_enable got=%b exp=0", enable); end
        $display("test_reset done");
    endtask

    // Continuous input from reset; registered outputs after iteration i belong to t=i.
    task automatic test_startup();
        for (int i = 0; i < 41; i++) begin
            in_valid = 1'b1;
            #1;
            checks++; if (enable !== 1'b1) begin failures++; $display("FAIL start_enable t=%0d got=%b exp=1", i, enable); end
            @(posedge clk); #1;
            if (i == 7 || i == 8 || i == 16) begin
                checks++; if (ctrl_bus[0] !== (i == 8)) begin failures++; $display("FAIL ctrl0 t=%0d got=%b exp=%b", i, ctrl_bus[0], (i == 8)); end
            end
            if (i == 8) begin
                checks++; if (addr_bus[31:16] !== 16'd0) begin failures++; $display("FAIL addr1_pre t=%0d got=%0d exp=0", i, addr_bus[31:16]); end
            end
            if (i >= 9 && i <= 20) begin
                checks++; if (addr_bus[31:16] !== a1_tab[(i - 9) % 4]) begin
                    failures++; $display("FAIL addr1 t=%0d got=%0d exp=%0d", i, addr_bus[31:16], a1_tab[(i - 9) % 4]); end
            end
            if (i <= 17) begin
                checks++; if (ctrl_bus[3] !== 1'b0) begin failures++; $display("FAIL ctrl3_low t=%0d got=%b exp=0", i, ctrl_bus[3]); end
            end
            if (i == 18) begin
                checks++; if (ctrl_bus[3] !== 1'b1) begin failures++; $display("FAIL ctrl3_rise t=%0d got=%b exp=1", i, ctrl_bus[3]); end
            end
            if (i == 18) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL out_valid_early t=%0d got=%b exp=0", i, out_valid); end
            end
            if (i >= 19) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL out_valid t=%0d got=%b exp=1", i, out_valid); end
                checks++; if (out_index !== idx_tab[(i - 19) % 16]) begin
                    failures++; $display("FAIL out_index t=%0d got=%0d exp=%0d", i, out_index, idx_tab[(i - 19) % 16]); end
                checks++; if (out_last !== (i == 34)) begin failures++; $display("FAIL out_last t=%0d got=%b exp=%b", i, out_last, (i == 34)); end
            end
        end
        $display("test_startup done");
    endtask

    task automatic test_midframe_reset();
        in_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0 || addr_bus !== 64'h0 || enable !== 1'b0) begin
            failures++; $display("FAIL midframe_reset valid=%b addr=%h en=%b exp=0", out_valid, addr_bus, enable); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("test_midframe_reset done");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b0;
            #1;
            checks++; if (enable !== 1'b0) begin failures++; $display("FAIL stall_enable cyc=%0d got=%b exp=0", i, enable); end
            @(posedge clk); #1;
            checks++; if (ctrl_bus !== 4'h0 || addr_bus !== 64'h5 || out_valid !== 1'b0) begin
                failures++; $display("FAIL stall_frozen cyc=%0d ctrl=%h addr=%h valid=%b exp ctrl=0 addr=5 valid=0", i, ctrl_bus, addr_bus, out_valid); end
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (addr_bus[15:0] !== a0_resume[i] || ctrl_bus[0] !== (i == 2)) begin
                failures++; $display("FAIL stall_resume t=%0d addr0=%0d ctrl0=%b exp addr0=%0d ctrl0=%b", i + 6, addr_bus[15:0], ctrl_bus[0], a0_resume[i], (i == 2)); end
        end
        $display("test_stall done");
    endtask

    // Continues the stalled frame from t=9; flush with input count 3 of frame 2, again at count 7.
    task automatic test_flush();
        int n_last;
        int done_n;
        for (int t = 9; t < 32; t++) begin
            in_valid = 1'b1;
            flush = (t == 19 || t == 23);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready t=%0d got=%b exp=1", t, in_ready); end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        n_last = 0;
        done_n = 0;
        for (int n = 1; n <= 40; n++) begin
            in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b0 || enable !== 1'b1) begin
                failures++; $display("FAIL drain_hs n=%0d in_ready=%b enable=%b exp 0/1", n, in_ready, enable); end
            @(posedge clk); #1;
            if (out_last === 1'b1) n_last++;
            if (n_last == 2) begin
                done_n = n;
                break;
            end
        end
        checks++; if (done_n !== 19) begin failures++; $display("FAIL drain_length got=%0d exp=19", done_n); end
        checks++; if (out_index !== idx_tab[15]) begin failures++; $display("FAIL drain_last_index got=%0d exp=%0d", out_index, idx_tab[15]); end
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || enable !== 1'b0) begin
            failures++; $display("FAIL post_drain in_ready=%b enable=%b exp 1/0", in_ready, enable); end
        $display("test_flush done");
    endtask

    // Flush in IDLE is ignored; the next frame starts at t=0; a later flush drains it.
    task automatic test_idle_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            flush = (i == 18);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_flush_ready i=%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
            if (i == 0) begin
                checks++; if (addr_bus !== 64'h0 || ctrl_bus !== 4'h0 || out_valid !== 1'b0) begin
                    failures++; $display("FAIL restart_t0 addr=%h ctrl=%h valid=%b exp 0", addr_bus, ctrl_bus, out_valid); end
            end
            if (i == 1) begin
                checks++; if (addr_bus[15:0] !== 16'd1) begin failures++; $display("FAIL restart_t1 addr0=%0d exp=1", addr_bus[15:0]); end
            end
        end
        flush = 1'b0;
        $display("test_idle_flush done");
    endtask

    task automatic test_reset_in_drain();
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL in_drain got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (addr_bus[31:16] !== 16'd6) begin failures++; $display("FAIL drain_addr1 t=32 got=%0d exp=6", addr_bus[31:16]); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ctrl_bus !== 4'h0 || addr_bus !== 64'h0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== 4'h0) begin
            failures++; $display("FAIL drain_reset_out ctrl=%h addr=%h v=%b l=%b idx=%0d exp 0", ctrl_bus, addr_bus, out_valid, out_last, out_index); end
        checks++; if (in_ready !== 1'b1 || enable !== 1'b0) begin
            failures++; $display("FAIL drain_reset_hs in_ready=%b enable=%b exp 1/0", in_ready, enable); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (addr_bus[15:0] !== 16'(i) || out_valid !== 1'b0) begin
                failures++; $display("FAIL after_reset t=%0d addr0=%0d valid=%b exp addr0=%0d valid=0", i, addr_bus[15:0], out_valid, i); end
        end
        in_valid = 1'b0;
        $display("test_reset_in_drain done");
    endtask

    initial begin
        test_reset();
        test_startup();
        test_midframe_reset();
        test_stall();
        test_flush();
        test_idle_flush();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
